// File: rtl/d_reg_bank.sv
// Multi-channel clocked register bank: held value, valid flag, saturating load
// counter and delay line per channel. Change-detect pulse built only with D_REG_BANK_CHANGE_EN.
module d_reg_bank #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int STAGES   = 2,
   parameter int CNT_W    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic [CHANNELS-1:0]       en,
   input  logic                      clr,
   output logic [CHANNELS*WIDTH-1:0] q,
   output logic [CHANNELS-1:0]       q_valid,
   output logic [CHANNELS*WIDTH-1:0] q_dly,
   output logic [CHANNELS*CNT_W-1:0] load_cnt,
   output logic [CHANNELS-1:0]       changed
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0]    val_q [CHANNELS];
   logic [WIDTH-1:0]    val_d [CHANNELS];
   logic [CHANNELS-1:0] valid_q;
   logic [CHANNELS-1:0] valid_d;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];
   logic [WIDTH-1:0]    dly_q [CHANNELS][STAGES];
   logic [WIDTH-1:0]    dly_d [CHANNELS][STAGES];

   // Next-state for held value, valid, counter and delay line; clr outranks en.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         val_d[i]    = val_q[i];
         valid_d[i]  = valid_q[i];
         cnt_d[i]    = cnt_q[i];
         dly_d[i][0] = val_q[i];
         for (int k = 1; k < STAGES; k++) begin
            dly_d[i][k] = dly_q[i][k-1];
         end
         if (clr) begin
            val_d[i]   = {WIDTH{1'b0}};
            valid_d[i] = 1'b0;
            cnt_d[i]   = {CNT_W{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
               dly_d[i][k] = {WIDTH{1'b0}};
            end
         end else if (en[i]) begin
            val_d[i]   = d[i*WIDTH +: WIDTH];
            valid_d[i] = 1'b1;
            if (cnt_q[i] != CNT_MAX) begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
               cnt_d[i] = CNT_MAX;
            end
         end else begin
            val_d[i]   = val_q[i];
            valid_d[i] = valid_q[i];
            cnt_d[i]   = cnt_q[i];
         end
      end
   end

   // State registers with asynchronous clear on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= {CHANNELS{1'b0}};
         for (int i = 0; i < CHANNELS; i++) begin
            val_q[i] <= {WIDTH{1'b0}};
            cnt_q[i] <= {CNT_W{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
               dly_q[i][k] <= {WIDTH{1'b0}};
            end
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < CHANNELS; i++) begin
            val_q[i] <= val_d[i];
            cnt_q[i] <= cnt_d[i];
            for (int k = 0; k < STAGES; k++) begin
               dly_q[i][k] <= dly_d[i][k];
            end
         end
      end
   end

`ifdef D_REG_BANK_CHANGE_EN
   logic [CHANNELS-1:0] chg_q;
   logic [CHANNELS-1:0] chg_d;

   // A load flags a change when the channel was empty or the data differs.
   always_comb begin
      chg_d = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         if (clr) begin
            chg_d[i] = 1'b0;
         end else if (en[i]) begin
            chg_d[i] = !valid_q[i] || (d[i*WIDTH +: WIDTH] != val_q[i]);
         end else begin
            chg_d[i] = 1'b0;
         end
      end
   end

   // Change-pulse register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chg_q <= {CHANNELS{1'b0}};
      end else begin
         chg_q <= chg_d;
      end
   end

   assign changed = chg_q;
`else
   assign changed = {CHANNELS{1'b0}};
`endif

   assign q_valid = valid_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign q[g*WIDTH +: WIDTH]        = val_q[g];
      assign q_dly[g*WIDTH +: WIDTH]    = dly_q[g][STAGES-1];
      assign load_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_d_reg_bank.sv
// Directed self-checking bench for d_reg_bank (default parameters); changed
// expectations follow D_REG_BANK_CHANGE_EN.
module tb_d_reg_bank;

   logic        clk;
   logic        rst;
   logic [31:0] d;
   logic [3:0]  en;
   logic        clr;
   logic [31:0] q;
   logic [3:0]  q_valid;
   logic [31:0] q_dly;
   logic [15:0] load_cnt;
   logic [3:0]  changed;

   int checks;
   int failures;

`ifdef D_REG_BANK_CHANGE_EN
   localparam logic [3:0] CHG_MASK = 4'b1111;
`else
   localparam logic [3:0] CHG_MASK = 4'b0000;
`endif

   d_reg_bank #(.WIDTH(8), .CHANNELS(4), .STAGES(2), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
      .q(q), .q_valid(q_valid), .q_dly(q_dly), .load_cnt(load_cnt), .changed(changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (q !== 32'h0 || q_valid !== 4'h0 || q_dly !== 32'h0 || load_cnt !== 16'h0 || changed !== 4'h0) begin
         failures++;
         $display("FAIL %s got q=%h v=%b dly=%h cnt=%h chg=%b exp all zero",
                  name, q, q_valid, q_dly, load_cnt, changed);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 4'h0; clr = 1'b0; d = 32'h0;
      step(); step();
      check_all_zero("reset_initial");
      rst = 1'b0;
   endtask

   task automatic test_single_load();
      d = 32'h000000A5; en = 4'b0001;
      step();
      en = 4'b0000;
      checks++;
      if (q !== 32'h000000A5) begin failures++; $display("FAIL single_q got=%h exp=%h", q, 32'h000000A5); end
      checks++;
      if (q_valid !== 4'b0001) begin failures++; $display("FAIL single_valid got=%b exp=%b", q_valid, 4'b0001); end
      checks++;
      if (changed !== (4'b0001 & CHG_MASK)) begin failures++; $display("FAIL single_changed got=%b exp=%b", changed, 4'b0001 & CHG_MASK); end
      checks++;
      if (load_cnt !== 16'h0001) begin failures++; $display("FAIL single_cnt got=%h exp=%h", load_cnt, 16'h0001); end
      step();
      checks++;
      if (q_dly !== 32'h0 || changed !== 4'h0) begin failures++; $display("FAIL single_dly1 got dly=%h chg=%b exp dly=0 chg=0", q_dly, changed); end
      step();
      checks++;
      if (q_dly !== 32'h000000A5) begin failures++; $display("FAIL single_dly2 got=%h exp=%h", q_dly, 32'h000000A5); end
   endtask

   task automatic test_repeat_change();
      d = 32'h000000A5; en = 4'b0001;
      step();
      checks++;
      if (changed !== 4'b0000 || load_cnt !== 16'h0002) begin
         failures++; $display("FAIL repeat_same got chg=%b cnt=%h exp chg=0000 cnt=0002", changed, load_cnt);
      end
      d = 32'h0000003C;
      step();
      en = 4'b0000;
      checks++;
      if (q !== 32'h0000003C || changed !== (4'b0001 & CHG_MASK) || load_cnt !== 16'h0003) begin
         failures++; $display("FAIL repeat_diff got q=%h chg=%b cnt=%h exp q=0000003c chg=%b cnt=0003",
                              q, changed, load_cnt, 4'b0001 & CHG_MASK);
      end
      step();
      checks++;
      if (changed !== 4'b0000) begin failures++; $display("FAIL repeat_pulse got=%b exp=0000", changed); end
   endtask

   task automatic test_saturation();
      d = 32'h00001100; en = 4'b0010;
      repeat (15) step();
      checks++;
      if (load_cnt[7:4] !== 4'hF) begin failures++; $display("FAIL sat_reach got=%h exp=f", load_cnt[7:4]); end
      repeat (5) step();
      en = 4'b0000;
      checks++;
      if (load_cnt !== 16'h00F3) begin failures++; $display("FAIL sat_hold got=%h exp=%h", load_cnt, 16'h00F3); end
      checks++;
      if (changed !== 4'b0000 || q !== 32'h0000113C) begin
         failures++; $display("FAIL sat_state got q=%h chg=%b exp q=0000113c chg=0000", q, changed);
      end
   endtask

   task automatic test_clr_priority();
      d = 32'hFFFFFFFF; en = 4'b1111; clr = 1'b1;
      step();
      clr = 1'b0;
      check_all_zero("clr_over_en");
      d = 32'h44332211; en = 4'b0101;
      step();
      en = 4'b0000;
      checks++;
      if (q_valid !== 4'b0101 || q !== 32'h00330011 || load_cnt !== 16'h0101) begin
         failures++; $display("FAIL clr_next got v=%b q=%h cnt=%h exp v=0101 q=00330011 cnt=0101", q_valid, q, load_cnt);
      end
      checks++;
      if (changed !== (4'b0101 & CHG_MASK) || q_dly !== 32'h0) begin
         failures++; $display("FAIL clr_next_chg got chg=%b dly=%h exp chg=%b dly=0", changed, q_dly, 4'b0101 & CHG_MASK);
      end
   endtask

   task automatic test_reset_mid();
      step();
      rst = 1'b1;
      #2;
      check_all_zero("reset_async");
      d = 32'h12345678; en = 4'b1111;
      step();
      check_all_zero("reset_held");
      rst = 1'b0; d = 32'h77000000; en = 4'b1000;
      step();
      en = 4'b0000;
      checks++;
      if (q !== 32'h77000000 || q_valid !== 4'b1000 || load_cnt !== 16'h1000) begin
         failures++; $display("FAIL reset_first_load got q=%h v=%b cnt=%h exp q=77000000 v=1000 cnt=1000", q, q_valid, load_cnt);
      end
   endtask

   task automatic test_independence();
      logic [3:0]  en_t  [7];
      logic [31:0] d_t   [7];
      logic [31:0] q_t   [7];
      logic [31:0] dly_t [7];
      en_t = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
      d_t  = '{32'hDEADBE10, 32'hDEAD21EF, 32'hDE32BEEF, 32'h43ADBEEF, 32'hDEADBE14, 32'hFFFFFFFF, 32'hFFFFFFFF};
      q_t  = '{32'h00000010, 32'h00002110, 32'h00322110, 32'h43322110, 32'h43322114, 32'h43322114, 32'h43322114};
      dly_t = '{32'h0, 32'h0, 32'h00000010, 32'h00002110, 32'h00322110, 32'h43322110, 32'h43322114};
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int c = 0; c < 7; c++) begin
         d = d_t[c]; en = en_t[c];
         step();
         checks++;
         if (q !== q_t[c] || q_dly !== dly_t[c]) begin
            failures++; $display("FAIL indep_c%0d got q=%h dly=%h exp q=%h dly=%h", c, q, q_dly, q_t[c], dly_t[c]);
         end
      end
      en = 4'b0000;
      checks++;
      if (load_cnt !== 16'h1112 || q_valid !== 4'b1111) begin
         failures++; $display("FAIL indep_cnt got cnt=%h v=%b exp cnt=1112 v=1111", load_cnt, q_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d_t   [3];
      logic [3:0]  chg_t [3];
      d_t   = '{32'h00010000, 32'h00020000, 32'h00020000};
      chg_t = '{4'b0100, 4'b0100, 4'b0000};
      for (int c = 0; c < 3; c++) begin
         d = d_t[c]; en = 4'b0100;
         step();
         checks++;
         if (changed !== (chg_t[c] & CHG_MASK) || q[23:16] !== d_t[c][23:16]) begin
            failures++; $display("FAIL b2b_c%0d got chg=%b q2=%h exp chg=%b q2=%h",
                                 c, changed, q[23:16], chg_t[c] & CHG_MASK, d_t[c][23:16]);
         end
      end
      en = 4'b0000;
      checks++;
      if (load_cnt !== 16'h1412) begin failures++; $display("FAIL b2b_cnt got=%h exp=1412", load_cnt); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_single_load();
      test_repeat_change();
      test_saturation();
      test_clr_priority();
      test_reset_mid();
      test_independence();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
